imu_frame_assembler: RTL and testbench
======================================

// Module: imu_frame_assembler
// PURPOSE
//  Upstream stage of the Madgwick filter core. Collects a tagged stream of raw IMU words
//  (a_x,a_y,a_z,w_x,w_y,w_z) from the sensor reader and checks their order. Emits one
//  complete 6-axis frame per valid/ready handshake into the filter's a_*/w_* inputs.
//  Double-buffered, so frame N+1 is collected while frame N waits for the filter.
// PARAMETERS
//  DATA_W   16  width of incoming sample word
//  ACC_W    16  accel field width (<= DATA_W; low ACC_W bits of s_data used)
//  GYRO_W   16  gyro field width (<= DATA_W; low GYRO_W bits of s_data used)
//  CNT_W    8   width of the saturating error/overrun counters
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous reset, active high
//  flush        in   1       synchronous clear of partial and held frames
//  s_valid      in   1       input word valid
//  s_ready      out  1       input word accepted when s_valid&&s_ready
//  s_tag        in   3       channel: 0=a_x 1=a_y 2=a_z 3=w_x 4=w_y 5=w_z, 6/7 illegal
//  s_data       in   DATA_W  sample value
//  m_valid      out  1       frame valid to filter
//  m_ready      in   1       filter accepts frame
//  m_a_x/y/z    out  ACC_W   frame accel fields (held stable while m_valid)
//  m_w_x/y/z    out  GYRO_W  frame gyro fields (held stable while m_valid)
//  seq_err_cnt  out  CNT_W   saturating count of sequence errors
//  overrun_cnt  out  CNT_W   saturating count of overwritten frames (0 without macro)
// BEHAVIOUR
//  - Reset (async): idx=0, collect buffer=0, m_valid=0, all m_* fields=0, both counters=0,
//    s_ready=0 while rst high. s_ready rises on the first clk after rst falls.
//  - Collect: 3-bit idx = expected tag. An accepted word with s_tag==idx stores into the
//    collect buffer and increments idx. At idx==5 the accepted word completes the frame.
//  - Sequence error (s_tag!=idx): seq_err_cnt+1 (saturates at all-ones).
//    Partial frame discarded. If s_tag==0, word is kept as a new frame start (idx=1);
//    otherwise word dropped and idx=0. Tag 0 arriving at idx==0 is not an error.
//  - Frame transfer: the completed frame loads into the output regs on the cycle after the
//    last word; m_valid=1 from that cycle. Latency: last word accept -> m_valid = 1 clk.
//  - Output handshake: frame consumed on m_valid&&m_ready. m_valid falls next cycle unless
//    a new frame loads in that same cycle, in which case m_valid stays 1 with new data.
//  - Backpressure (macro off): s_ready=0 only when idx==5 && m_valid && !m_ready;
//    otherwise s_ready=1. No frame is ever lost.
//  - flush: next cycle idx=0, m_valid=0. Counters are kept. flush overrides a simultaneous
//    input accept or output handshake; that word/frame is discarded.
//  - Partial frame with no further input: held indefinitely. No timeout.
// CONFIGURATION
//  IMU_FRAME_OVERWRITE_EN defined:
//  - s_ready=1 always after reset.
//  - If a frame completes while the held frame is unconsumed (m_valid && !m_ready),
//    the held frame is replaced, m_valid stays 1 and overrun_cnt+1 (saturating).
//  - Newest data wins, so a stalled filter never stalls the sensor reader.
//  IMU_FRAME_OVERWRITE_EN undefined:
//  - Backpressure as above; overrun_cnt tied to 0.
// TESTING
//  1. Tags 0..5, data 0x0011..0x0066, m_ready=1 -> m_valid one cycle after tag-5 accept;
//     m_a_x=0x0011 .. m_w_z=0x0066; seq_err_cnt=0.
//  2. Tags 0,1,3 -> seq_err_cnt=1, tag-3 word dropped; then 0..5 -> one clean frame out.
//  3. Tags 0,1,0,1,2,3,4,5 -> seq_err_cnt=1; one frame out holding the 2nd tag-0/1 values.
//  4. m_ready=0, two full frames sent, macro off -> s_ready=0 on 2nd tag-5; raise m_ready
//     -> frame1 then frame2 delivered in order, no loss.
//  5. Same as 4 with IMU_FRAME_OVERWRITE_EN -> s_ready stays 1, overrun_cnt=1,
//     only frame2 visible on m_*.
//  6. rst pulse mid-frame (idx=3) with m_valid=1 -> m_valid=0, counters=0;
//     next tags 0..5 yield a correct frame.

Source files
------------

// File: rtl/imu_frame_assembler.sv
// imu_frame_assembler: orders tagged IMU words into double-buffered 6-axis frames for the filter.
// Optional macro IMU_FRAME_OVERWRITE_EN: newest frame overwrites an unconsumed one instead of stalling input.
module imu_frame_assembler #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 16,
  parameter int GYRO_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [2:0]        s_tag,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_a_x,
  output logic [ACC_W-1:0]  m_a_y,
  output logic [ACC_W-1:0]  m_a_z,
  output logic [GYRO_W-1:0] m_w_x,
  output logic [GYRO_W-1:0] m_w_y,
  output logic [GYRO_W-1:0] m_w_z,
  output logic [CNT_W-1:0]  seq_err_cnt,
  output logic [CNT_W-1:0]  overrun_cnt
);
  logic [2:0]        idx;
  logic              en;
  logic [ACC_W-1:0]  c_ax, c_ay, c_az;
  logic [GYRO_W-1:0] c_wx, c_wy;
  logic              acc, hit, done, ov_hit;
`ifdef IMU_FRAME_OVERWRITE_EN
  assign s_ready = en;
  assign ov_hit  = done && m_valid && !m_ready;
`else
  // Stall only the frame-completing word while the held frame is still unconsumed
  assign s_ready = en && !(idx == 3'd5 && m_valid && !m_ready);
  assign ov_hit  = 1'b0;
`endif
  assign acc  = s_valid && s_ready && !flush;
  assign hit  = acc && s_tag == idx;
  assign done = hit && idx == 3'd5;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en          <= 1'b0;
      idx         <= 3'd0;
      c_ax        <= '0;
      c_ay        <= '0;
      c_az        <= '0;
      c_wx        <= '0;
      c_wy        <= '0;
      m_valid     <= 1'b0;
      m_a_x       <= '0;
      m_a_y       <= '0;
      m_a_z       <= '0;
      m_w_x       <= '0;
      m_w_y       <= '0;
      m_w_z       <= '0;
      seq_err_cnt <= '0;
      overrun_cnt <= '0;
    end else begin
      en <= 1'b1;
      if (flush) begin
        idx     <= 3'd0;
        m_valid <= 1'b0;
      end else begin
        if (acc) begin
          if (hit) idx <= done ? 3'd0 : idx + 3'd1;
          else begin
            seq_err_cnt <= seq_err_cnt + {{(CNT_W-1){1'b0}}, ~&seq_err_cnt};
            idx         <= (s_tag == 3'd0) ? 3'd1 : 3'd0;
          end
          // A mismatched tag 0 still starts a fresh frame
          if (hit || s_tag == 3'd0) begin
            if (s_tag == 3'd0) c_ax <= s_data[ACC_W-1:0];
            if (s_tag == 3'd1) c_ay <= s_data[ACC_W-1:0];
            if (s_tag == 3'd2) c_az <= s_data[ACC_W-1:0];
            if (s_tag == 3'd3) c_wx <= s_data[GYRO_W-1:0];
            if (s_tag == 3'd4) c_wy <= s_data[GYRO_W-1:0];
          end
        end
        if (done) begin
          m_valid <= 1'b1;
          m_a_x   <= c_ax;
          m_a_y   <= c_ay;
          m_a_z   <= c_az;
          m_w_x   <= c_wx;
          m_w_y   <= c_wy;
          m_w_z   <= s_data[GYRO_W-1:0];
          if (ov_hit) overrun_cnt <= overrun_cnt + {{(CNT_W-1){1'b0}}, ~&overrun_cnt};
        end else if (m_valid && m_ready) m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imu_frame_assembler.sv
// tb_imu_frame_assembler: directed self-checking bench for imu_frame_assembler.
// Overwrite scenario runs when IMU_FRAME_OVERWRITE_EN is defined, backpressure otherwise.
module tb_imu_frame_assembler;
  logic        clk = 0, rst = 0, flush = 0, s_valid = 0, m_ready = 1;
  logic [2:0]  s_tag = 0;
  logic [15:0] s_data = 0;
  logic        s_ready, m_valid;
  logic [15:0] m_a_x, m_a_y, m_a_z, m_w_x, m_w_y, m_w_z;
  logic [7:0]  seq_err_cnt, overrun_cnt;
  logic [95:0] frame;
  int tests = 0, fails = 0;

  imu_frame_assembler dut (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_tag(s_tag), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_a_x(m_a_x), .m_a_y(m_a_y), .m_a_z(m_a_z), .m_w_x(m_w_x), .m_w_y(m_w_y),
    .m_w_z(m_w_z), .seq_err_cnt(seq_err_cnt), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;
  assign frame = {m_a_x, m_a_y, m_a_z, m_w_x, m_w_y, m_w_z};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] t, input logic [15:0] d);
    int n = 0;
    s_valid = 1; s_tag = t; s_data = d;
    while (!s_ready && n < 20) begin tick(); n++; end
    if (!s_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout tag=%0d s_ready=%b required 1", t, s_ready);
    end
    tick();
    s_valid = 0;
  endtask

  task automatic send_frame(input logic [15:0] base);
    for (int i = 0; i < 6; i++) send(3'(i), base + 16'(17 * (i + 1)));
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #2;
    tests++; if (m_valid !== 1'b0 || s_ready !== 1'b0) begin fails++; $display("FAIL reset_hs m_valid=%b s_ready=%b required 0 0", m_valid, s_ready); end
    tests++; if (frame !== 96'd0 || seq_err_cnt !== 8'd0 || overrun_cnt !== 8'd0) begin fails++; $display("FAIL reset_regs frame=%h seq=%0d ov=%0d required 0", frame, seq_err_cnt, overrun_cnt); end
    tick();
    rst = 0;
    #1;
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_early s_ready=%b required 0", s_ready); end
    tick();
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_rise s_ready=%b required 1", s_ready); end
  endtask

  task automatic test_frame();
    m_ready = 1;
    send_frame(16'h0000);
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL frame_latency m_valid=%b required 1", m_valid); end
    tests++; if (frame !== 96'h0011_0022_0033_0044_0055_0066) begin fails++; $display("FAIL frame_data got %h required 001100220033004400550066", frame); end
    tick();
    tests++; if (m_valid !== 1'b0 || seq_err_cnt !== 8'd0) begin fails++; $display("FAIL frame_consume m_valid=%b seq=%0d required 0 0", m_valid, seq_err_cnt); end
  endtask

  task automatic test_seq_err();
    send(0, 16'h0A0A); send(1, 16'h0B0B); send(3, 16'h0C0C);
    tests++; if (seq_err_cnt !== 8'd1 || m_valid !== 1'b0) begin fails++; $display("FAIL seq_err cnt=%0d m_valid=%b required 1 0", seq_err_cnt, m_valid); end
    send_frame(16'h0100);
    tests++; if (m_valid !== 1'b1 || frame !== 96'h0111_0122_0133_0144_0155_0166) begin fails++; $display("FAIL seq_err_frame v=%b got %h required 1 011101220133014401550166", m_valid, frame); end
    tick();
  endtask

  task automatic test_restart();
    send(0, 16'hAAAA); send(1, 16'hBBBB);
    send_frame(16'h0200);
    tests++; if (seq_err_cnt !== 8'd2) begin fails++; $display("FAIL restart_cnt got %0d required 2", seq_err_cnt); end
    tests++; if (m_valid !== 1'b1 || frame !== 96'h0211_0222_0233_0244_0255_0266) begin fails++; $display("FAIL restart_frame v=%b got %h required 1 021102220233024402550266", m_valid, frame); end
    tick();
  endtask

  task automatic test_illegal_tag();
    send(7, 16'hFFFF);
    tests++; if (seq_err_cnt !== 8'd3) begin fails++; $display("FAIL illegal_tag cnt=%0d required 3", seq_err_cnt); end
    send_frame(16'h0300);
    tests++; if (m_valid !== 1'b1 || frame !== 96'h0311_0322_0333_0344_0355_0366) begin fails++; $display("FAIL illegal_frame v=%b got %h required 1 031103220333034403550366", m_valid, frame); end
    tick();
  endtask

  task automatic test_flush();
    send(0, 16'h1111); send(1, 16'h2222); send(2, 16'h3333);
    flush = 1; tick(); flush = 0;
    send(3, 16'h4444);
    tests++; if (seq_err_cnt !== 8'd4) begin fails++; $display("FAIL flush_idx cnt=%0d required 4", seq_err_cnt); end
    m_ready = 0;
    send_frame(16'h0400);
    flush = 1; tick(); flush = 0;
    tests++; if (m_valid !== 1'b0 || seq_err_cnt !== 8'd4) begin fails++; $display("FAIL flush_out m_valid=%b cnt=%0d required 0 4", m_valid, seq_err_cnt); end
    m_ready = 1;
  endtask

`ifdef IMU_FRAME_OVERWRITE_EN
  task automatic test_overwrite();
    m_ready = 0;
    send_frame(16'h0500);
    for (int i = 0; i < 5; i++) send(3'(i), 16'h0600 + 16'(17 * (i + 1)));
    s_valid = 1; s_tag = 5; s_data = 16'h0666;
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL ow_ready s_ready=%b required 1", s_ready); end
    tick(); s_valid = 0;
    tests++; if (overrun_cnt !== 8'd1 || m_valid !== 1'b1) begin fails++; $display("FAIL ow_cnt ov=%0d v=%b required 1 1", overrun_cnt, m_valid); end
    tests++; if (frame !== 96'h0611_0622_0633_0644_0655_0666) begin fails++; $display("FAIL ow_frame got %h required 061106220633064406550666", frame); end
    m_ready = 1; tick();
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL ow_drain m_valid=%b required 0", m_valid); end
  endtask
`else
  task automatic test_backpressure();
    m_ready = 0;
    send_frame(16'h0500);
    for (int i = 0; i < 5; i++) send(3'(i), 16'h0600 + 16'(17 * (i + 1)));
    s_valid = 1; s_tag = 5; s_data = 16'h0666;
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL bp_ready s_ready=%b required 0", s_ready); end
    tick(); tick();
    tests++; if (m_valid !== 1'b1 || frame !== 96'h0511_0522_0533_0544_0555_0566) begin fails++; $display("FAIL bp_frame1 v=%b got %h required 1 051105220533054405550566", m_valid, frame); end
    m_ready = 1;
    #1;
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL bp_release s_ready=%b required 1", s_ready); end
    tick(); s_valid = 0;
    tests++; if (m_valid !== 1'b1 || frame !== 96'h0611_0622_0633_0644_0655_0666) begin fails++; $display("FAIL bp_frame2 v=%b got %h required 1 061106220633064406550666", m_valid, frame); end
    tick();
    tests++; if (m_valid !== 1'b0 || overrun_cnt !== 8'd0) begin fails++; $display("FAIL bp_drain v=%b ov=%0d required 0 0", m_valid, overrun_cnt); end
  endtask
`endif

  task automatic test_rst_mid();
    m_ready = 0;
    send_frame(16'h0700);
    send(0, 16'h0801); send(1, 16'h0802); send(2, 16'h0803);
    rst = 1;
    #1;
    tests++; if (m_valid !== 1'b0 || seq_err_cnt !== 8'd0 || overrun_cnt !== 8'd0 || s_ready !== 1'b0) begin fails++; $display("FAIL rst_mid v=%b seq=%0d ov=%0d rdy=%b required 0 0 0 0", m_valid, seq_err_cnt, overrun_cnt, s_ready); end
    #2 rst = 0;
    tick();
    m_ready = 1;
    send_frame(16'h0900);
    tests++; if (m_valid !== 1'b1 || frame !== 96'h0911_0922_0933_0944_0955_0966 || seq_err_cnt !== 8'd0) begin fails++; $display("FAIL rst_mid_frame v=%b got %h seq=%0d required 1 091109220933094409550966 0", m_valid, frame, seq_err_cnt); end
    tick();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) send(6, 16'(i));
    tests++; if (seq_err_cnt !== 8'hFF) begin fails++; $display("FAIL saturate got %0d required 255", seq_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_seq_err();
    test_restart();
    test_illegal_tag();
    test_flush();
`ifdef IMU_FRAME_OVERWRITE_EN
    test_overwrite();
`else
    test_backpressure();
`endif
    test_rst_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
